// File: rtl/aes_stream_ctrl.sv
// Host-side stream controller for a 4x32-bit AES block engine: packs host words into
// blocks, applies ECB/CBC/CFB chaining around the engine and unpacks results to the host.
module aes_stream_ctrl #(
    parameter int WORDS = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iParam_load,
    input  logic         iEndec,
    input  logic [1:0]   iMode,
    input  logic [127:0] iIV,
    output logic         oErr,
    input  logic         iWr_valid,
    input  logic [31:0]  iWr_data,
    output logic         oWr_ready,
    output logic         oRd_valid,
    output logic [31:0]  oRd_data,
    input  logic         iRd_ready,
    output logic         oEng_param_load,
    output logic         oEng_endec,
    output logic [1:0]   oEng_mode,
    output logic         oEng_data_valid,
    output logic [31:0]  oEng_data_1,
    output logic [31:0]  oEng_data_2,
    output logic [31:0]  oEng_data_3,
    output logic [31:0]  oEng_data_4,
    input  logic         iEng_busy,
    input  logic         iEng_data_valid,
    input  logic [31:0]  iEng_data_1,
    input  logic [31:0]  iEng_data_2,
    input  logic [31:0]  iEng_data_3,
    input  logic [31:0]  iEng_data_4,
    output logic [1:0]   oState
);

    localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CFB = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } stateT;

    stateT        state;
    logic [1:0]   wordCount;
    logic [1:0]   rdIdx;
    logic [127:0] plainBlk;
    logic [127:0] chain;
    logic [127:0] outBlk;
    logic [127:0] engData;
    logic [1:0]   modeReg;
    logic         endecReg;
    logic         errReg;
    logic         engParamLoad;
    logic         engDataValid;
    logic         rdValid;
    logic [31:0]  rdData;

    logic         acceptParam;
    logic         wrReady;
    logic         wrFire;
    logic [127:0] engIn;
    logic [127:0] engResult;
    logic [127:0] outNext;
    logic [127:0] chainNext;

    function automatic logic [31:0] wordOf(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    // A param load at an empty FILL takes priority over a coinciding host write.
    always_comb begin
        acceptParam = iParam_load && (state == S_FILL) && (wordCount == 2'd0);
        wrReady     = (state == S_FILL) && !errReg && !acceptParam;
        wrFire      = iWr_valid && wrReady;
    end

    always_comb begin
        engIn = plainBlk;
        case (modeReg)
            MODE_CBC: engIn = endecReg ? plainBlk : (plainBlk ^ chain);
            MODE_CFB: engIn = chain;
            default:  engIn = plainBlk;
        endcase
    end

    // Chain update uses the plaintext/ciphertext block still held in plainBlk.
    always_comb begin
        engResult = {iEng_data_1, iEng_data_2, iEng_data_3, iEng_data_4};
        outNext   = engResult;
        chainNext = chain;
        case (modeReg)
            MODE_CBC: begin
                if (endecReg) begin
                    outNext   = engResult ^ chain;
                    chainNext = plainBlk;
                end else begin
                    outNext   = engResult;
                    chainNext = engResult;
                end
            end
            MODE_CFB: begin
                outNext   = engResult ^ plainBlk;
                chainNext = endecReg ? plainBlk : (engResult ^ plainBlk);
            end
            default: begin
                outNext   = engResult;
                chainNext = chain;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= S_FILL;
            wordCount    <= 2'd0;
            rdIdx        <= 2'd0;
            plainBlk     <= '0;
            chain        <= '0;
            outBlk       <= '0;
            engData      <= '0;
            modeReg      <= MODE_ECB;
            endecReg     <= 1'b0;
            errReg       <= 1'b0;
            engParamLoad <= 1'b0;
            engDataValid <= 1'b0;
            rdValid      <= 1'b0;
            rdData       <= '0;
        end else begin
            engParamLoad <= 1'b0;
            engDataValid <= 1'b0;
            case (state)
                S_FILL: begin
                    if (acceptParam) begin
                        modeReg      <= iMode;
                        endecReg     <= iEndec;
                        chain        <= iIV;
                        errReg       <= (iMode == MODE_BAD);
                        engParamLoad <= 1'b1;
                    end else if (wrFire) begin
                        case (wordCount)
                            2'd0:    plainBlk[127:96] <= iWr_data;
                            2'd1:    plainBlk[95:64]  <= iWr_data;
                            2'd2:    plainBlk[63:32]  <= iWr_data;
                            default: plainBlk[31:0]   <= iWr_data;
                        endcase
                        if (wordCount == LAST_WORD) begin
                            wordCount <= 2'd0;
                            state     <= S_ISSUE;
                        end else begin
                            wordCount <= wordCount + 2'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!iEng_busy) begin
                        engData      <= engIn;
                        engDataValid <= 1'b1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iEng_data_valid) begin
                        outBlk  <= outNext;
                        chain   <= chainNext;
                        rdData  <= wordOf(outNext, 2'd0);
                        rdValid <= 1'b1;
                        rdIdx   <= 2'd0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (iRd_ready) begin
                        if (rdIdx == LAST_WORD) begin
                            rdValid <= 1'b0;
                            state   <= S_FILL;
                        end else begin
                            rdIdx  <= rdIdx + 2'd1;
                            rdData <= wordOf(outBlk, rdIdx + 2'd1);
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Host handshakes are valid/ready: a word moves on any clock edge where both are high.
    assign oErr            = errReg;
    assign oWr_ready       = wrReady;
    assign oRd_valid       = rdValid;
    assign oRd_data        = rdData;
    assign oEng_param_load = engParamLoad;
    assign oEng_endec      = endecReg;
    assign oEng_mode       = modeReg;
    assign oEng_data_valid = engDataValid;
    assign oEng_data_1     = engData[127:96];
    assign oEng_data_2     = engData[95:64];
    assign oEng_data_3     = engData[63:32];
    assign oEng_data_4     = engData[31:0];
    assign oState          = state;

endmodule
